lsu_mem_port: RTL and testbench

Parametrised load/store unit between the core execute stage and the data memory, replacing the single-outstanding `mem_stage` counter inside the core.
- Accepts LD/ST requests over a valid/ready handshake and issues them to dmem with the codebase's valid/yumi protocol.
- Allows up to `outstanding_p` requests in flight; responses retire strictly in order.
- Supports byte, half and word accesses, with sign or zero extension on loads.
- Returns load data tagged with the destination register for writeback.

---
 rtl/lsu_mem_port_pkg.sv | 36 +++
 rtl/lsu_meta_fifo.sv | 58 +++++
 rtl/lsu_mem_port.sv | 165 ++++++++++++++++
 tb/tb_lsu_mem_port.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_port_pkg.sv
// ---------------------------------------------------------------------------
// lsu_mem_port_pkg : access-size encoding and response-metadata types for LSU
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_mem_port_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    // Fixed-width part of the metadata; tag and byte offset are appended by the
    // user because their widths follow the instantiating parameters.
    typedef struct packed {
        logic      wen;
        mem_size_e size;
        logic      sgn;
    } lsu_meta_s;

    localparam int unsigned C_META_HDR_W = $bits(lsu_meta_s);

    function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~lo[0];
            2'b10:   return (lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_meta_fifo.sv
// ---------------------------------------------------------------------------
// lsu_meta_fifo : width/depth parametrised synchronous FIFO, async low reset
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_meta_fifo #(
    parameter int unsigned width_p = 8,
    parameter int unsigned depth_p = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int unsigned C_PTR_W = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int unsigned C_CNT_W = $clog2(depth_p + 1);

    logic [width_p-1:0] mem_q [depth_p];
    logic [C_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [C_CNT_W-1:0] count_q;
    logic               w_push, w_pop;

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_PTR_W'(depth_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == C_CNT_W'(depth_p));
    assign w_pop   = pop_i & ~empty_o;
    // A full FIFO may still accept when the head leaves in the same cycle.
    assign w_push  = push_i & (~full_o | w_pop);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(depth_p); i++) mem_q[i] <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port : load/store unit with bounded in-flight requests, in-order retire
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int unsigned data_width_p  = 32,
    parameter int unsigned addr_width_p  = 32,
    parameter int unsigned tag_width_p   = 5,
    parameter int unsigned outstanding_p = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic                                 req_wen_i,
    input  logic [1:0]                           req_size_i,
    input  logic                                 req_signed_i,
    input  logic [addr_width_p-1:0]              req_addr_i,
    input  logic [data_width_p-1:0]              req_wdata_i,
    input  logic [tag_width_p-1:0]               req_tag_i,
    output logic                                 mem_valid_o,
    output logic                                 mem_wen_o,
    output logic [1:0]                           mem_size_o,
    output logic [addr_width_p-1:0]              mem_addr_o,
    output logic [data_width_p-1:0]              mem_wdata_o,
    input  logic                                 mem_yumi_i,
    input  logic                                 mem_resp_valid_i,
    input  logic [data_width_p-1:0]              mem_rdata_i,
    output logic                                 mem_resp_yumi_o,
    output logic                                 wb_valid_o,
    input  logic                                 wb_ready_i,
    output logic [data_width_p-1:0]              wb_data_o,
    output logic [tag_width_p-1:0]               wb_tag_o,
    output logic                                 store_done_o,
    output logic [$clog2(outstanding_p+1)-1:0]   inflight_o,
    output logic                                 idle_o,
    output logic                                 exception_o
);

    localparam int unsigned C_LO_W   = $clog2(data_width_p / 8);
    localparam int unsigned C_IF_W   = $clog2(outstanding_p + 1);
    localparam int unsigned C_META_W = C_META_HDR_W + tag_width_p + C_LO_W;
    localparam int unsigned C_LANES_B = data_width_p / 8;
    localparam int unsigned C_LANES_H = data_width_p / 16;
    localparam logic [C_IF_W-1:0] C_MAX = C_IF_W'(outstanding_p);

    logic                    slot_v_q;
    lsu_meta_s               slot_meta_q;
    logic [tag_width_p-1:0]  slot_tag_q;
    logic [addr_width_p-1:0] slot_addr_q;
    logic [data_width_p-1:0] slot_wdata_q;
    logic [C_IF_W-1:0]       inflight_q, inflight_d;
    logic                    exception_q, exception_d;

    logic                    w_aligned, w_take, w_accept, w_misalign, w_issue;
    logic                    w_pop, w_unexpected, w_full, w_empty;
    logic [data_width_p-1:0] w_wdata, w_shift;
    logic [C_META_W-1:0]     w_push_data, w_head;
    lsu_meta_s               w_head_meta;
    logic [C_LO_W-1:0]       w_head_lo;

    assign w_aligned   = size_aligned(req_size_i, req_addr_i[1:0]);
    assign req_ready_o = (~slot_v_q | mem_yumi_i) & (inflight_q < C_MAX);
    assign w_take      = req_valid_i & req_ready_o;
    assign w_accept    = w_take & w_aligned;
    assign w_misalign  = w_take & ~w_aligned;
    assign w_issue     = slot_v_q & mem_yumi_i;

    always_comb begin
        w_wdata = req_wdata_i;
        case (req_size_i)
            2'b00:   w_wdata = {C_LANES_B{req_wdata_i[7:0]}};
            2'b01:   w_wdata = {C_LANES_H{req_wdata_i[15:0]}};
            default: w_wdata = req_wdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_v_q     <= 1'b0;
            slot_meta_q  <= '0;
            slot_tag_q   <= '0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
        end else if (w_accept) begin
            slot_v_q     <= 1'b1;
            slot_meta_q  <= '{wen: req_wen_i, size: mem_size_e'(req_size_i), sgn: req_signed_i};
            slot_tag_q   <= req_tag_i;
            slot_addr_q  <= req_addr_i;
            slot_wdata_q <= w_wdata;
        end else if (w_issue) begin
            slot_v_q     <= 1'b0;
        end
    end

    assign mem_valid_o = slot_v_q;
    assign mem_wen_o   = slot_meta_q.wen;
    assign mem_size_o  = slot_meta_q.size;
    assign mem_addr_o  = slot_addr_q;
    assign mem_wdata_o = slot_wdata_q;

    assign w_push_data = {slot_meta_q, slot_tag_q, slot_addr_q[C_LO_W-1:0]};

    lsu_meta_fifo #(
        .width_p (C_META_W),
        .depth_p (outstanding_p)
    ) u_meta_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_issue & ~w_full),
        .data_i  (w_push_data),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_head_meta = lsu_meta_s'(w_head[C_META_W-1 -: C_META_HDR_W]);
    assign wb_tag_o    = w_head[C_LO_W +: tag_width_p];
    assign w_head_lo   = w_head[C_LO_W-1:0];

    // Loads wait for writeback; stores and stray responses drain immediately.
    assign wb_valid_o      = mem_resp_valid_i & ~w_empty & ~w_head_meta.wen;
    assign w_pop           = mem_resp_valid_i & ~w_empty & (w_head_meta.wen | wb_ready_i);
    assign w_unexpected    = mem_resp_valid_i & w_empty;
    assign mem_resp_yumi_o = w_pop | w_unexpected;
    assign store_done_o    = w_pop & w_head_meta.wen;

    assign w_shift = mem_rdata_i >> {w_head_lo, 3'b000};

    always_comb begin
        wb_data_o = w_shift;
        case (w_head_meta.size)
            BYTE:    wb_data_o = w_head_meta.sgn ? data_width_p'($signed(w_shift[7:0]))
                                                 : data_width_p'(w_shift[7:0]);
            HALF:    wb_data_o = w_head_meta.sgn ? data_width_p'($signed(w_shift[15:0]))
                                                 : data_width_p'(w_shift[15:0]);
            default: wb_data_o = w_shift;
        endcase
    end

    assign inflight_d  = inflight_q + C_IF_W'(w_accept) - C_IF_W'(w_pop);
    assign exception_d = exception_q | w_misalign | w_unexpected;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q  <= '0;
            exception_q <= 1'b0;
        end else begin
            inflight_q  <= inflight_d;
            exception_q <= exception_d;
        end
    end

    assign inflight_o  = inflight_q;
    assign idle_o      = (inflight_q == '0);
    assign exception_o = exception_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_port : directed self-checking bench with in-order result scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i, req_ready_o, req_wen_i, req_signed_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_tag_i;
    logic        mem_valid_o, mem_wen_o, mem_yumi_i, mem_resp_valid_i, mem_resp_yumi_o;
    logic [1:0]  mem_size_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        wb_valid_o, wb_ready_i, store_done_o, idle_o, exception_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_tag_o;
    logic [1:0]  inflight_o;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int      n_cmp = 0;
    int      n_err = 0;

    always #5 clk = ~clk;

    lsu_mem_port #(
        .data_width_p  (32),
        .addr_width_p  (32),
        .tag_width_p   (5),
        .outstanding_p (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_wen_i        (req_wen_i),
        .req_size_i       (req_size_i),
        .req_signed_i     (req_signed_i),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_tag_i        (req_tag_i),
        .mem_valid_o      (mem_valid_o),
        .mem_wen_o        (mem_wen_o),
        .mem_size_o       (mem_size_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_yumi_i       (mem_yumi_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_rdata_i      (mem_rdata_i),
        .mem_resp_yumi_o  (mem_resp_yumi_o),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_data_o        (wb_data_o),
        .wb_tag_o         (wb_tag_o),
        .store_done_o     (store_done_o),
        .inflight_o       (inflight_o),
        .idle_o           (idle_o),
        .exception_o      (exception_o)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_mem_valid"}, mem_valid_o, 1'b0);
        chk({pfx, "_req_ready"}, req_ready_o, 1'b1);
        chk({pfx, "_wb_valid"},  wb_valid_o,  1'b0);
        chk({pfx, "_store_done"}, store_done_o, 1'b0);
        chk({pfx, "_inflight"},  inflight_o,  2'd0);
        chk({pfx, "_idle"},      idle_o,      1'b1);
        chk({pfx, "_exception"}, exception_o, 1'b0);
    endtask

    task automatic issue(input logic wen, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg);
        logic acc;
        acc = 1'b0;
        req_valid_i = 1'b1; req_wen_i = wen; req_size_i = sz; req_signed_i = sg;
        req_addr_i = a; req_wdata_i = wd; req_tag_i = tg;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready_o) begin
                acc = 1'b1;
                tick();
                break;
            end
            tick();
        end
        req_valid_i = 1'b0;
        chk("issue_accepted", acc, 1'b1);
    endtask

    task automatic dmem_accept();
        chk("dmem_slot_valid", mem_valid_o, 1'b1);
        mem_yumi_i = 1'b1;
        tick();
        mem_yumi_i = 1'b0;
    endtask

    task automatic chk_wb();
        wb_exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 1'b0, 1'b1);
        end else begin
            e = sb_q.pop_front();
            chk("wb_data", wb_data_o, e.data);
            chk("wb_tag",  wb_tag_o,  e.tag);
        end
    endtask

    task automatic respond_load(input logic [31:0] rd);
        mem_resp_valid_i = 1'b1; mem_rdata_i = rd; wb_ready_i = 1'b1;
        #1;
        chk("load_wb_valid", wb_valid_o, 1'b1);
        chk_wb();
        chk("load_resp_yumi", mem_resp_yumi_o, 1'b1);
        tick();
        mem_resp_valid_i = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        req_valid_i = 1'b0; req_wen_i = 1'b0; req_size_i = 2'b00; req_signed_i = 1'b0;
        req_addr_i = '0; req_wdata_i = '0; req_tag_i = '0;
        mem_yumi_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = '0; wb_ready_i = 1'b1;
        tick(); tick();
        chk_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Word load with delayed dmem accept and response
        sb_q.push_back('{data: 32'hDEADBEEF, tag: 5'd3});
        issue(1'b0, 2'b10, 1'b0, 32'h10, '0, 5'd3);
        chk("wl_mem_valid", mem_valid_o, 1'b1);
        chk("wl_mem_addr",  mem_addr_o,  32'h10);
        chk("wl_mem_size",  mem_size_o,  2'b10);
        chk("wl_mem_wen",   mem_wen_o,   1'b0);
        chk("wl_inflight1", inflight_o,  2'd1);
        tick();
        chk("wl_slot_held", mem_valid_o, 1'b1);
        dmem_accept();
        chk("wl_slot_freed", mem_valid_o, 1'b0);
        tick(); tick();
        respond_load(32'hDEADBEEF);
        chk("wl_inflight0", inflight_o, 2'd0);
        chk("wl_idle", idle_o, 1'b1);

        // Sub-word loads with sign and zero extension
        sb_q.push_back('{data: 32'hFFFFFF80, tag: 5'd4});
        issue(1'b0, 2'b00, 1'b1, 32'h13, '0, 5'd4);
        dmem_accept(); tick();
        respond_load(32'h80FF0000);
        sb_q.push_back('{data: 32'h00000080, tag: 5'd5});
        issue(1'b0, 2'b00, 1'b0, 32'h13, '0, 5'd5);
        dmem_accept(); tick();
        respond_load(32'h80FF0000);
        sb_q.push_back('{data: 32'hFFFF80FF, tag: 5'd6});
        issue(1'b0, 2'b01, 1'b1, 32'h12, '0, 5'd6);
        dmem_accept(); tick();
        respond_load(32'h80FF0000);

        // Outstanding limit with dmem always accepting
        sb_q.push_back('{data: 32'h11111111, tag: 5'd10});
        sb_q.push_back('{data: 32'h22222222, tag: 5'd11});
        sb_q.push_back('{data: 32'h33333333, tag: 5'd12});
        mem_yumi_i = 1'b1;
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_size_i = 2'b10; req_signed_i = 1'b0;
        req_addr_i = 32'h100; req_tag_i = 5'd10;
        #1; chk("ol_ready_a", req_ready_o, 1'b1);
        tick();
        req_addr_i = 32'h104; req_tag_i = 5'd11;
        #1; chk("ol_ready_b", req_ready_o, 1'b1);
        tick();
        req_addr_i = 32'h108; req_tag_i = 5'd12;
        #1; chk("ol_ready_c_blocked", req_ready_o, 1'b0);
        chk("ol_inflight2", inflight_o, 2'd2);
        tick();
        chk("ol_ready_still_blocked", req_ready_o, 1'b0);
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h11111111; wb_ready_i = 1'b1;
        #1; chk("ol_wb_valid_a", wb_valid_o, 1'b1);
        chk_wb();
        tick();
        mem_rdata_i = 32'h22222222;
        #1; chk("ol_ready_after_retire", req_ready_o, 1'b1);
        chk("ol_wb_valid_b", wb_valid_o, 1'b1);
        chk_wb();
        tick();
        req_valid_i = 1'b0; mem_resp_valid_i = 1'b0;
        chk("ol_inflight_same_cycle", inflight_o, 2'd1);
        chk("ol_c_presented", mem_addr_o, 32'h108);
        tick();
        mem_yumi_i = 1'b0;
        respond_load(32'h33333333);
        chk("ol_inflight0", inflight_o, 2'd0);

        // Stores: lane replication and retire pulse
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB, 5'd0);
        chk("st_wdata_byte", mem_wdata_o, 32'hABABABAB);
        chk("st_size", mem_size_o, 2'b00);
        chk("st_wen", mem_wen_o, 1'b1);
        dmem_accept(); tick();
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h0;
        #1;
        chk("st_no_wb", wb_valid_o, 1'b0);
        chk("st_done", store_done_o, 1'b1);
        chk("st_resp_yumi", mem_resp_yumi_o, 1'b1);
        tick();
        mem_resp_valid_i = 1'b0;
        #1; chk("st_done_pulse_end", store_done_o, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h00001234, 5'd0);
        chk("st_wdata_half", mem_wdata_o, 32'h12341234);
        dmem_accept(); tick();
        mem_resp_valid_i = 1'b1;
        #1; chk("st_half_done", store_done_o, 1'b1);
        tick();
        mem_resp_valid_i = 1'b0;

        // Misaligned word load
        chk("ma_exc_before", exception_o, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h02, '0, 5'd1);
        chk("ma_not_issued", mem_valid_o, 1'b0);
        chk("ma_not_counted", inflight_o, 2'd0);
        chk("ma_exc_set", exception_o, 1'b1);
        tick(); tick();
        chk("ma_exc_sticky", exception_o, 1'b1);

        // Writeback backpressure
        sb_q.push_back('{data: 32'h12345678, tag: 5'd7});
        issue(1'b0, 2'b10, 1'b0, 32'h40, '0, 5'd7);
        dmem_accept(); tick();
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'h12345678; wb_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_wb_valid", wb_valid_o, 1'b1);
            chk("bp_no_yumi", mem_resp_yumi_o, 1'b0);
            chk("bp_data_held", wb_data_o, 32'h12345678);
            tick();
        end
        chk("bp_still_inflight", inflight_o, 2'd1);
        respond_load(32'h12345678);

        // Reset with two requests in flight, then a stale response
        issue(1'b0, 2'b10, 1'b0, 32'h50, '0, 5'd1);
        dmem_accept();
        issue(1'b0, 2'b10, 1'b0, 32'h54, '0, 5'd2);
        chk("rs_inflight2", inflight_o, 2'd2);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        sb_q.delete();
        tick();
        reset = 1'b1;
        tick();
        mem_resp_valid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D; wb_ready_i = 1'b1;
        #1;
        chk("stray_yumi", mem_resp_yumi_o, 1'b1);
        chk("stray_no_wb", wb_valid_o, 1'b0);
        tick();
        mem_resp_valid_i = 1'b0;
        chk("stray_exception", exception_o, 1'b1);
        chk("stray_inflight", inflight_o, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
